// File: rtl/somador_pkg.sv
// Shared constants and helpers for the block-serial adder.
package somador_pkg;

    // Controller state encoding; 2'd3 is unused and decodes to IDLE.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SOMA = 2'd1;
    localparam logic [1:0] FIM  = 2'd2;

    // Ceiling log2 with a floor of one bit, used to size the block index.
    function automatic int clog2_min1(input int value);
        int res;
        res = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 32'sd1;
            end else begin
                res = res;
            end
        end
        if (res < 32'sd1) begin
            res = 32'sd1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/somador_carry_look_ahead_param.sv
// N-bit carry look-ahead adder: every carry is expanded as a sum of
// generate/propagate products rather than rippled bit to bit.
module somador_carry_look_ahead_param #(
    parameter int N = 32'sd8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;
    logic         prod_s;
    logic         acc_s;

    // Look-ahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s    = '0;
        prod_s = 1'b1;
        acc_s  = 1'b0;
        c_s[0] = c_in;
        for (int i = 32'sd0; i < N; i++) begin
            prod_s = 1'b1;
            acc_s  = 1'b0;
            for (int j = i; j >= 32'sd0; j--) begin
                acc_s  = acc_s | (prod_s & g_s[j]);
                prod_s = prod_s & p_s[j];
            end
            c_s[i+1] = acc_s | (prod_s & c_in);
        end
    end

    assign s     = p_s ^ c_s[N-1:0];
    assign c_out = c_s[N];

endmodule

// File: rtl/somador_multiciclo_blocos.sv
// Block-serial wide adder: latches W-bit operands on start, then pushes
// one N-bit block per cycle (LSB first) through a single N-bit CLA adder,
// chaining the carry through a register and assembling the sum in S.
module somador_multiciclo_blocos
    import somador_pkg::*;
#(
    parameter  int N = 32'sd8,
    parameter  int K = 32'sd4,
    localparam int W = N * K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         C_out
);

    localparam int               IDX_W    = clog2_min1(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 32'sd1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(32'sd1);

    logic [1:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             carry_r;
    logic [W-1:0]     s_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;

    logic [N-1:0]     a_blk_s;
    logic [N-1:0]     b_blk_s;
    logic [N-1:0]     sum_blk_s;
    logic             cout_blk_s;

    // Select the operand block addressed by the current index.
    always_comb begin
        a_blk_s = a_r[idx_r*N +: N];
        b_blk_s = b_r[idx_r*N +: N];
    end

    somador_carry_look_ahead_param #(
        .N (N)
    ) u_cla (
        .a     (a_blk_s),
        .b     (b_blk_s),
        .c_in  (carry_r),
        .s     (sum_blk_s),
        .c_out (cout_blk_s)
    );

    // Sequencer: operand capture, per-block accumulation and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            s_r     <= '0;
            c_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= C_in;
                        idx_r   <= '0;
                        s_r     <= '0;
                        c_out_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= SOMA;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SOMA: begin
                    s_r[idx_r*N +: N] <= sum_blk_s;
                    carry_r           <= cout_blk_s;
                    busy_r            <= 1'b1;
                    if (idx_r == LAST_IDX) begin
                        c_out_r <= cout_blk_s;
                        done_r  <= 1'b1;
                        state_r <= FIM;
                    end else begin
                        idx_r   <= idx_r + ONE_IDX;
                    end
                end
                FIM: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign S     = s_r;
    assign C_out = c_out_r;

endmodule

// File: tb/tb_somador_multiciclo_blocos.sv
// Scoreboard bench: stimulus pushes expected {C_out,S}; monitors pop and
// compare whenever done is seen. Covers K=4 and K=1 instances.
module tb_somador_multiciclo_blocos;

    logic        clk;
    logic        rst;
    logic        start0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        cin0;
    logic        busy0;
    logic        done0;
    logic [31:0] s0;
    logic        cout0;

    logic        start1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        cin1;
    logic        busy1;
    logic        done1;
    logic [7:0]  s1;
    logic        cout1;

    int checks = 0;
    int errors = 0;

    logic [32:0] q0[$];
    logic [8:0]  q1[$];

    somador_multiciclo_blocos #(.N(8), .K(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .C_in(cin0),
        .busy(busy0), .done(done0), .S(s0), .C_out(cout0)
    );

    somador_multiciclo_blocos #(.N(8), .K(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .C_in(cin1),
        .busy(busy1), .done(done1), .S(s1), .C_out(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the K=4 instance.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done0: got done=1 expected no pending result at %0t", $time);
            end else begin
                chk("result0", {31'd0, cout0, s0}, {31'd0, q0.pop_front()});
            end
        end
    end

    // Monitor for the K=1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got done=1 expected no pending result at %0t", $time);
            end else begin
                chk("result1", {55'd0, cout1, s1}, {55'd0, q1.pop_front()});
            end
        end
    end

    // Issue one K=4 operation and check busy/done timing through cycle t+6.
    task automatic run_check(input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic [32:0] exp);
        q0.push_back(exp);
        a0 = a; b0 = b; cin0 = cin; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("busy_timing", {63'd0, busy0}, {63'd0, (i <= 5)});
            chk("done_timing", {63'd0, done0}, {63'd0, (i == 5)});
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_busy",  {63'd0, busy0}, 64'd0);
        chk("reset_done",  {63'd0, done0}, 64'd0);
        chk("reset_S",     {32'd0, s0},    64'd0);
        chk("reset_C_out", {63'd0, cout0}, 64'd0);
        rst = 1'b0;
        tick();

        // Full carry chain through every block.
        run_check(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000});
        // Carry-in used, no block overflow.
        run_check(32'h1234_5678, 32'h1111_1111, 1'b1, {1'b0, 32'h2345_678A});

        // Ignored starts and operand changes during an operation.
        q0.push_back({1'b0, 32'h0100_0000});
        a0 = 32'h00FF_FFFF; b0 = 32'h0000_0001; cin0 = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; cin0 = 1'b1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("ignored_start_idle", {63'd0, busy0}, 64'd0);

        // Reset mid-operation: no result expected, start with rst ignored.
        a0 = 32'hAAAA_5555; b0 = 32'h1111_2222; cin0 = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        rst = 1'b1; start0 = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_busy",  {63'd0, busy0}, 64'd0);
        chk("midrst_done",  {63'd0, done0}, 64'd0);
        chk("midrst_S",     {32'd0, s0},    64'd0);
        chk("midrst_C_out", {63'd0, cout0}, 64'd0);
        rst = 1'b0; start0 = 1'b0;
        tick();
        chk("midrst_no_restart", {63'd0, busy0}, 64'd0);
        run_check(32'd5, 32'd7, 1'b0, {1'b0, 32'd12});

        // start held high: re-triggers every K+2 cycles.
        for (int i = 0; i < 3; i++) q0.push_back({1'b1, 32'h0000_0000});
        a0 = 32'h8000_0000; b0 = 32'h8000_0000; cin0 = 1'b0; start0 = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            @(negedge clk);
            chk("held_start_done", {63'd0, done0}, {63'd0, (i % 6 == 5)});
        end
        start0 = 1'b0;
        tick();

        // K=1 instance: done two cycles after start.
        q1.push_back({1'b1, 8'h11});
        a1 = 8'hF0; b1 = 8'h20; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("k1_busy", {63'd0, busy1}, {63'd0, (i <= 2)});
            chk("k1_done", {63'd0, done1}, {63'd0, (i == 2)});
            tick();
        end

        for (int i = 0; i < 4; i++) tick();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
